// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-cache memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned BEAT_W     = 2;
    localparam logic [ADDR_W-1:0] LINE_MASK = 32'hFFFF_FFF0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    // Word request presented to the backing memory
    typedef struct packed {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Align an address down to the start of its cache line
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return addr & LINE_MASK;
    endfunction

endpackage

// File: rtl/mem_arb_beat_cnt.sv
// Beat counter and word address generator for one cache-line burst.
module mem_arb_beat_cnt
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_ack,
    input  logic [ADDR_W-1:0] i_base,
    output logic [BEAT_W-1:0] o_beat,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [BEAT_W-1:0] r_beat;

    // Advance one beat per acknowledged word; clear wins over ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat <= '0;
        end else if (i_clear) begin
            r_beat <= '0;
        end else if (i_ack) begin
            r_beat <= r_beat + BEAT_W'(1);
        end
    end

    assign o_beat = r_beat;
    assign o_addr = i_base + ADDR_W'({r_beat, 2'b00});
    assign o_last = (r_beat == BEAT_W'(LINE_WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates Icache refills and Dcache refills/writebacks onto one memory port.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on ties;
// otherwise the Dcache always wins a tie.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icache_req_i,
    input  logic [31:0] icache_addr_i,
    output logic [31:0] icache_rdata_o,
    output logic        icache_rvalid_o,
    output logic        icache_done_o,
    input  logic        dcache_req_i,
    input  logic        dcache_we_i,
    input  logic [31:0] dcache_addr_i,
    input  logic [31:0] dcache_wdata_i,
    output logic [31:0] dcache_rdata_o,
    output logic        dcache_rvalid_o,
    output logic        dcache_done_o,
    output logic [1:0]  beat_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        busy_o
);

    arb_state_e        r_state;
    arb_state_e        w_next;
    logic              r_owner_d;
    logic              w_pick_d;
    logic              w_active;
    logic              w_ack;
    logic              w_last;
    logic              w_clear;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_cnt_addr;
    logic [BEAT_W-1:0] w_beat;
    mem_cmd_t          w_cmd;

    assign w_active = (r_state == ST_GNT_I) || (r_state == ST_GNT_D);
    assign w_ack    = w_active & mem_ack_i;
    assign w_clear  = ~w_active | (w_ack & w_last);
    assign w_base   = line_base((r_state == ST_GNT_D) ? dcache_addr_i : icache_addr_i);

`ifdef MEM_ARB_RR_EN
    logic r_ptr_d;

    // Pointer remembers the loser of the last grant; it wins the next tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr_d <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_ptr_d <= ~r_owner_d;
        end
    end

    // Dcache wins alone, or on a tie when the pointer names it
    always_comb begin
        w_pick_d = dcache_req_i & (~icache_req_i | r_ptr_d);
    end
`else
    // Fixed priority: Dcache wins any tie
    always_comb begin
        w_pick_d = dcache_req_i;
    end
`endif

    // Beat counter and line address generation
    mem_arb_beat_cnt u_beat_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_clear),
        .i_ack   (w_ack),
        .i_base  (w_base),
        .o_beat  (w_beat),
        .o_addr  (w_cnt_addr),
        .o_last  (w_last)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Remember who was granted so DONE can route the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner_d <= 1'b0;
        end else if ((r_state == ST_IDLE) && (w_next != ST_IDLE)) begin
            r_owner_d <= (w_next == ST_GNT_D);
        end
    end

    // Next-state: grant only from IDLE, leave a grant on the last beat's ack
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_d) begin
                    w_next = ST_GNT_D;
                end else if (icache_req_i) begin
                    w_next = ST_GNT_I;
                end
            end
            ST_GNT_I, ST_GNT_D: begin
                if (w_ack && w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Output decode: memory command, per-requester read data and done
    always_comb begin
        w_cmd           = '0;
        icache_rdata_o  = '0;
        icache_rvalid_o = 1'b0;
        icache_done_o   = 1'b0;
        dcache_rdata_o  = '0;
        dcache_rvalid_o = 1'b0;
        dcache_done_o   = 1'b0;
        busy_o          = (r_state != ST_IDLE);
        beat_o          = w_beat;
        if (w_active) begin
            w_cmd.req  = 1'b1;
            w_cmd.addr = w_cnt_addr;
        end
        if ((r_state == ST_GNT_D) && dcache_we_i) begin
            w_cmd.we    = 1'b1;
            w_cmd.wdata = dcache_wdata_i;
        end
        if ((r_state == ST_GNT_I) && mem_ack_i) begin
            icache_rvalid_o = 1'b1;
            icache_rdata_o  = mem_rdata_i;
        end
        if ((r_state == ST_GNT_D) && !dcache_we_i && mem_ack_i) begin
            dcache_rvalid_o = 1'b1;
            dcache_rdata_o  = mem_rdata_i;
        end
        if (r_state == ST_DONE) begin
            icache_done_o = ~r_owner_d;
            dcache_done_o = r_owner_d;
        end
    end

    assign mem_req_o   = w_cmd.req;
    assign mem_we_o    = w_cmd.we;
    assign mem_addr_o  = w_cmd.addr;
    assign mem_wdata_o = w_cmd.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icache_req_i, dcache_req_i, dcache_we_i, mem_ack_i;
    logic [31:0] icache_addr_i, dcache_addr_i, dcache_wdata_i, mem_rdata_i;
    logic [31:0] icache_rdata_o, dcache_rdata_o, mem_addr_o, mem_wdata_o;
    logic        icache_rvalid_o, icache_done_o, dcache_rvalid_o, dcache_done_o;
    logic        mem_req_o, mem_we_o, busy_o;
    logic [1:0]  beat_o;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .icache_req_i    (icache_req_i),
        .icache_addr_i   (icache_addr_i),
        .icache_rdata_o  (icache_rdata_o),
        .icache_rvalid_o (icache_rvalid_o),
        .icache_done_o   (icache_done_o),
        .dcache_req_i    (dcache_req_i),
        .dcache_we_i     (dcache_we_i),
        .dcache_addr_i   (dcache_addr_i),
        .dcache_wdata_i  (dcache_wdata_i),
        .dcache_rdata_o  (dcache_rdata_o),
        .dcache_rvalid_o (dcache_rvalid_o),
        .dcache_done_o   (dcache_done_o),
        .beat_o          (beat_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_rdata_i     (mem_rdata_i),
        .mem_ack_i       (mem_ack_i),
        .busy_o          (busy_o)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: a line transfer in progress, its owner,
    // how many words are already transferred, and a pending done pulse.
    bit m_active, m_done, m_own_d, m_ptr;
    int m_beat;
    int gap_cnt;
    int ack_mode;   // 0: ack always high, 1: random, 2: ack every third busy cycle
    bit wb_mode;    // writeback data follows the expected beat index
    int i_more, d_more;

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a - (a % 32'd16);
    endfunction

    task automatic model_reset();
        m_active = 0; m_done = 0; m_own_d = 0; m_ptr = 0; m_beat = 0; gap_cnt = 0;
    endtask

    task automatic model_update();
        if (!rst_n) begin
            model_reset();
        end else if (m_active) begin
            gap_cnt++;
            if (mem_ack_i) begin
                if (m_beat == 3) begin
                    m_active = 0; m_done = 1; m_beat = 0;
                end else begin
                    m_beat++;
                end
            end
        end else if (m_done) begin
            m_done = 0;
            m_ptr  = !m_own_d;
        end else if (icache_req_i || dcache_req_i) begin
            m_own_d  = dcache_req_i && (!icache_req_i || (RR ? m_ptr : 1'b1));
            m_active = 1; m_beat = 0; gap_cnt = 0;
        end
    endtask

    task automatic compare_all();
        logic [31:0] base, e_addr, e_wd;
        bit e_we, e_ri, e_rd;
        base   = m_own_d ? line_of(dcache_addr_i) : line_of(icache_addr_i);
        e_addr = m_active ? base + 32'(4 * m_beat) : 32'd0;
        e_we   = m_active && m_own_d && dcache_we_i;
        e_wd   = e_we ? dcache_wdata_i : 32'd0;
        e_ri   = m_active && !m_own_d && mem_ack_i;
        e_rd   = m_active && m_own_d && !dcache_we_i && mem_ack_i;
        check("busy",     32'(busy_o),          32'(m_active || m_done));
        check("mem_req",  32'(mem_req_o),       32'(m_active));
        check("mem_we",   32'(mem_we_o),        32'(e_we));
        check("mem_addr", mem_addr_o,           e_addr);
        check("mem_wd",   mem_wdata_o,          e_wd);
        check("beat",     32'(beat_o),          32'(m_beat));
        check("i_rvalid", 32'(icache_rvalid_o), 32'(e_ri));
        check("i_rdata",  icache_rdata_o,       e_ri ? mem_rdata_i : 32'd0);
        check("i_done",   32'(icache_done_o),   32'(m_done && !m_own_d));
        check("d_rvalid", 32'(dcache_rvalid_o), 32'(e_rd));
        check("d_rdata",  dcache_rdata_o,       e_rd ? mem_rdata_i : 32'd0);
        check("d_done",   32'(dcache_done_o),   32'(m_done && m_own_d));
    endtask

    // Drive this cycle's memory inputs, then compare mid-cycle
    task automatic settle();
        case (ack_mode)
            0:       mem_ack_i = 1'b1;
            1:       mem_ack_i = 1'($urandom_range(0, 1));
            default: mem_ack_i = m_active && (gap_cnt % 3 == 2);
        endcase
        mem_rdata_i = $urandom;
        dcache_wdata_i = wb_mode ? 32'(m_beat) * 32'h1111 : $urandom;
        #3;
        compare_all();
    endtask

    // Advance the model over the clock edge; requesters drop req after done
    task automatic finish_cycle();
        bit di, dd;
        di = m_done && !m_own_d;
        dd = m_done && m_own_d;
        @(posedge clk);
        model_update();
        #1;
        if (di) begin
            if (i_more > 0) i_more--; else icache_req_i = 1'b0;
        end
        if (dd) begin
            if (d_more > 0) d_more--; else dcache_req_i = 1'b0;
        end
    endtask

    task automatic tick();
        settle();
        finish_cycle();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((icache_req_i || dcache_req_i || m_active || m_done) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int ord[$];
        int exp_ord[$];
        int k, n, cyc, last_ack;
        bit seen;
        int i_low, d_low;
        logic [31:0] wd_tab [4];

        wd_tab = '{32'h0, 32'h1111, 32'h2222, 32'h3333};
        rst_n = 1'b0;
        icache_req_i = 0; dcache_req_i = 0; dcache_we_i = 0; mem_ack_i = 0;
        icache_addr_i = 0; dcache_addr_i = 0; dcache_wdata_i = 0; mem_rdata_i = 0;
        ack_mode = 0; wb_mode = 0; i_more = 0; d_more = 0;
        model_reset();
        @(posedge clk); #1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Simultaneous requests straight out of reset
        icache_addr_i = 32'h0000_0100; dcache_addr_i = 32'h0000_0200; dcache_we_i = 0;
        icache_req_i = 1; dcache_req_i = 1;
        i_more = RR ? 1 : 0; d_more = RR ? 1 : 0;
        if (RR) exp_ord = '{0, 1, 0, 1}; else exp_ord = '{1, 0};
        n = 0;
        while ((icache_req_i || dcache_req_i || m_active || m_done) && n < 200) begin
            settle();
            if (icache_done_o) ord.push_back(0);
            if (dcache_done_o) ord.push_back(1);
            finish_cycle();
            n++;
        end
        check("t031_count", 32'(ord.size()), 32'(exp_ord.size()));
        for (int i = 0; i < exp_ord.size(); i++)
            check($sformatf("t031_grant%0d", i), (i < ord.size()) ? 32'(ord[i]) : 32'd99, 32'(exp_ord[i]));
        drain("t031");

        // Icache refill alone, ack every cycle
        ack_mode = 0; icache_addr_i = 32'h0000_1234; icache_req_i = 1;
        k = 0; cyc = 0; last_ack = -10; n = 0;
        while ((icache_req_i || m_active || m_done) && n < 40) begin
            settle();
            if (icache_rvalid_o) begin
                check("t030_addr", mem_addr_o, 32'h0000_1230 + 32'(4 * k));
                k++;
                last_ack = cyc;
            end
            if (icache_done_o) check("t030_done_lat", 32'(cyc - last_ack), 32'd1);
            finish_cycle();
            cyc++; n++;
        end
        check("t030_beats", 32'(k), 32'd4);

        // Dcache writeback with two idle cycles between acks
        ack_mode = 2; wb_mode = 1; dcache_addr_i = 32'h0000_2000; dcache_we_i = 1; dcache_req_i = 1;
        k = 0; n = 0;
        while ((dcache_req_i || m_active || m_done) && n < 60) begin
            settle();
            if (m_active) check("t032_req_held", 32'(mem_req_o), 32'd1);
            if (m_active && mem_ack_i && k < 4) begin
                check("t032_we", 32'(mem_we_o), 32'd1);
                check("t032_wdata", mem_wdata_o, wd_tab[k]);
                k++;
            end
            check("t032_no_rvalid", 32'(dcache_rvalid_o), 32'd0);
            finish_cycle();
            n++;
        end
        check("t032_beats", 32'(k), 32'd4);
        wb_mode = 0; dcache_we_i = 0;

        // Icache request raised in the middle of a Dcache refill
        dcache_addr_i = 32'h0000_3040; dcache_req_i = 1;
        repeat (3) tick();
        icache_addr_i = 32'h0000_5678; icache_req_i = 1;
        seen = 0; n = 0;
        while (!seen && n < 60) begin
            settle();
            seen = dcache_done_o;
            finish_cycle();
            n++;
        end
        check("t033_d_done", 32'(seen), 32'd1);
        settle();
        check("t033_idle_gap", 32'(busy_o), 32'd0);
        finish_cycle();
        settle();
        check("t033_i_granted", 32'(mem_req_o), 32'd1);
        check("t033_i_addr", mem_addr_o, 32'h0000_5670);
        finish_cycle();
        drain("t033");

        // Reset pulsed after beat 1 of a refill
        ack_mode = 0; icache_addr_i = 32'h0000_1234; icache_req_i = 1;
        n = 0;
        while (m_beat != 2 && n < 20) begin
            tick();
            n++;
        end
        check("t034_reached_beat2", 32'(m_beat), 32'd2);
        rst_n = 1'b0;
        #1;
        check("t034_rst_req", 32'(mem_req_o), 32'd0);
        check("t034_rst_addr", mem_addr_o, 32'd0);
        check("t034_rst_beat", 32'(beat_o), 32'd0);
        check("t034_rst_busy", 32'(busy_o), 32'd0);
        check("t034_rst_rvalid", 32'(icache_rvalid_o), 32'd0);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        settle();
        check("t034_restart_beat", 32'(beat_o), 32'd0);
        check("t034_restart_addr", mem_addr_o, 32'h0000_1230);
        finish_cycle();
        drain("t034");

        // Ack while idle is ignored
        ack_mode = 0;
        repeat (3) begin
            settle();
            check("t035_rvalid", 32'(icache_rvalid_o | dcache_rvalid_o), 32'd0);
            check("t035_beat", 32'(beat_o), 32'd0);
            finish_cycle();
        end

        // Random traffic: requests of random type and address, random acks
        ack_mode = 1; i_low = 0; d_low = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!icache_req_i) begin
                if (i_low > 0 && $urandom_range(0, 5) == 0) begin
                    icache_addr_i = $urandom; icache_req_i = 1; i_low = 0;
                end else i_low++;
            end
            if (!dcache_req_i) begin
                if (d_low > 0 && $urandom_range(0, 5) == 0) begin
                    dcache_addr_i = $urandom; dcache_we_i = 1'($urandom_range(0, 1));
                    dcache_req_i = 1; d_low = 0;
                end else d_low++;
            end
            tick();
        end
        drain("rand");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got=running expected=finished");
        n_bad++;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  input  1  core clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 icache_req_i  input  1  Icache line-refill request; held high until icache_done_o.
REQ-004 icache_addr_i  input  32  Icache miss address; stable while icache_req_i is high.
REQ-005 icache_rdata_o / icache_rvalid_o  output  32 / 1  refill beat data, with a one-cycle valid per beat.
REQ-006 icache_done_o  output  1  one-cycle pulse after the last refill beat.
REQ-007 dcache_req_i, dcache_we_i  input  1, 1  Dcache line request; we=1 means writeback, we=0 means refill; both held until dcache_done_o.
REQ-008 dcache_addr_i  input  32  Dcache line address; stable while dcache_req_i is high.
REQ-009 dcache_wdata_i  input  32  writeback word for the beat given by beat_o.
REQ-010 dcache_rdata_o / dcache_rvalid_o / dcache_done_o  output  32 / 1 / 1  same meaning as the Icache equivalents.
REQ-011 beat_o  output  2  current beat index in the active transaction.
REQ-012 mem_req_o, mem_we_o  output  1, 1  word request to the shared backing memory, and its write enable.
REQ-013 mem_addr_o, mem_wdata_o  output  32, 32  word address and write data to the backing memory.
REQ-014 mem_rdata_i, mem_ack_i  input  32, 1  memory read data, and beat-complete acknowledge (may arrive any cycle ≥1 after request).
REQ-015 busy_o  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, GNT_I, GNT_D, DONE.
- REQ-016a IDLE→GNT_I or GNT_D on a request, chosen per REQ-017.
- REQ-016b GNT_x→DONE on the ack of beat 3.
- REQ-016c DONE→IDLE unconditionally after one cycle.
REQ-017 Arbitration with both requests high in IDLE: Dcache wins (default, see REQ-027).
REQ-018 The grant is sampled only in IDLE; a transaction is never pre-empted.
REQ-019 Line size: 4 words of 32 bits.
- REQ-019a Line base = addr & 32'hFFFF_FFF0.
- REQ-019b mem_addr_o = base + (beat_o << 2).
REQ-020 mem_req_o is high continuously in GNT_I/GNT_D.
- REQ-020a beat_o increments by 1 on each mem_ack_i.
- REQ-020b beat_o clears to 0 on entry to DONE.
REQ-021 Read transactions:
- REQ-021a rdata_o = mem_rdata_i and rvalid_o = 1 in the ack cycle, to the granted requester only.
- REQ-021b The ungranted requester sees rvalid_o = 0.
REQ-022 Writeback: mem_we_o = 1 and mem_wdata_o = dcache_wdata_i during GNT_D with dcache_we_i = 1; rvalid_o stays 0.
REQ-023 done_o pulses high in DONE to the granted requester only; the requester drops req no earlier than the cycle after done.
REQ-024 mem_ack_i in IDLE or DONE is ignored and has no state effect.
REQ-025 In IDLE and DONE: mem_req_o = 0; mem_addr_o, mem_wdata_o and mem_we_o = 0.

Reset
REQ-026 rst_n low asserted at any time, including mid-burst:
- REQ-026a FSM goes to IDLE, beat counter to 0, round-robin pointer to Icache.
- REQ-026b All outputs go to 0 immediately.
- REQ-026c The interrupted transaction is abandoned; no done pulse is issued.

Configuration
REQ-027 Macro MEM_ARB_RR_EN:
- REQ-027a Defined: round-robin arbitration. A 1-bit pointer marks the loser of the last grant, updated in DONE; on a tie the pointed-to requester wins.
- REQ-027b Undefined: fixed Dcache priority per REQ-017; no pointer register exists.

Structure
REQ-028 Shared package mem_arb_pkg holds:
- the state enum;
- LINE_WORDS = 4;
- BEAT_W = 2;
- LINE_MASK = 32'hFFFF_FFF0.
REQ-029 A sub-module mem_arb_beat_cnt holds the beat counter and address generation (inputs: clear, ack, base; outputs: beat, addr, last).

Verification
REQ-030 Icache refill alone:
- Stimulus: addr 32'h0000_1234, ack every cycle.
- Response: mem_addr_o = 1230, 1234, 1238, 123C on consecutive cycles; 4 icache_rvalid_o; icache_done_o 1 cycle after the last ack.
REQ-031 Simultaneous requests in IDLE:
- MEM_ARB_RR_EN undefined: Dcache granted first, Icache second.
- MEM_ARB_RR_EN defined: grants alternate over 4 back-to-back transactions, I, D, I, D from reset.
REQ-032 Dcache writeback:
- Stimulus: addr 32'h0000_2000; wdata = beat_o*16'h1111; acks with 2-cycle gaps.
- Response: mem_we_o = 1; mem_wdata_o = 0, 1111, 2222, 3333; mem_req_o held through the gaps; no rvalid.
REQ-033 Icache request raised mid Dcache burst: the Dcache burst completes; Icache is granted in the IDLE cycle after DONE.
REQ-034 rst_n pulsed low after beat 1 of a refill:
- Response: all outputs 0 immediately; no done pulse.
- After release with req still high: the transaction restarts at beat 0.
REQ-035 mem_ack_i asserted in IDLE: no rvalid, beat_o stays 0.
